// File: rtl/ram_arbiter.sv
// ram_arbiter
// Arbitrates two request/acknowledge ports (A and B) onto one single-port
// RAM. Each transaction takes three cycles: IDLE samples the request,
// ACCESS drives the RAM for one cycle, and RESP pulses the owner's ack.
// When both ports request in the same IDLE cycle, the port that was not
// granted last wins.
//
// Ports
//   clock, reset_n              clock; synchronous active-low reset
//   req_x, we_x, addr_x,        requester x (x = a, b): level request held
//   wdata_x                     until ack, write flag, word address, write data
//   ack_x, rdata_x              one-cycle completion pulse; read data that
//                               stays valid after the pulse
//   ram_cs, ram_we, ram_addr,   RAM control and write data. The RAM writes on
//   ram_wdata                   the negedge while ram_cs and ram_we are high.
//   ram_rdata                   asynchronous RAM read data for ram_addr
//   busy                        high whenever the arbiter is not IDLE
module ram_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_a,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] wdata_a,
   output logic              ack_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic              req_b,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              ack_b,
   output logic [DATA_W-1:0] rdata_b,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_reg, state_next;
   logic              owner_reg, owner_next;            // 0 = A, 1 = B
   logic              last_grant_reg, last_grant_next;  // 0 = A, 1 = B
   logic              ram_cs_reg, ram_cs_next;
   logic              ram_we_reg, ram_we_next;
   logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
   logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;
   logic              busy_reg, busy_next;
   logic              grant;

   logic [DATA_W-1:0] rdata_arr [2];
   logic              ack_arr   [2];

   // State and RAM-side output registers
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         owner_reg      <= 1'b0;
         last_grant_reg <= 1'b1;   // B counts as last, so A wins the first tie
         ram_cs_reg     <= 1'b0;
         ram_we_reg     <= 1'b0;
         ram_addr_reg   <= '0;
         ram_wdata_reg  <= '0;
         busy_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_grant_reg <= last_grant_next;
         ram_cs_reg     <= ram_cs_next;
         ram_we_reg     <= ram_we_next;
         ram_addr_reg   <= ram_addr_next;
         ram_wdata_reg  <= ram_wdata_next;
         busy_reg       <= busy_next;
      end
   end

   // Next-state logic. RAM address and write data keep their last value
   // outside ACCESS; chip select and write enable default low.
   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_grant_next = last_grant_reg;
      ram_cs_next     = 1'b0;
      ram_we_next     = 1'b0;
      ram_addr_next   = ram_addr_reg;
      ram_wdata_next  = ram_wdata_reg;
      busy_next       = 1'b0;
      grant           = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req_a || req_b) begin
               // Tie goes to the port not granted last; otherwise, if only
               // one port requests, req_b alone selects the winner.
               grant          = (req_a && req_b) ? ~last_grant_reg : req_b;
               owner_next     = grant;
               ram_cs_next    = 1'b1;
               ram_we_next    = grant ? we_b    : we_a;
               ram_addr_next  = grant ? addr_b  : addr_a;
               ram_wdata_next = grant ? wdata_b : wdata_a;
               busy_next      = 1'b1;
               state_next     = ACCESS;
            end
         end
         ACCESS: begin
            busy_next  = 1'b1;
            state_next = RESP;
         end
         RESP: begin
            last_grant_next = owner_reg;
            state_next      = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Per-port response registers. At the end of ACCESS the owner captures
   // ram_rdata (the RAM has already written at the mid-cycle negedge, so a
   // write returns the written word) and raises its ack for the RESP cycle.
   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] rdata_reg;
      logic              ack_reg;
      logic              own;

      assign own = (state_reg == ACCESS) && (owner_reg == 1'(gi));

      always_ff @(posedge clock) begin
         if (!reset_n) begin
            rdata_reg <= '0;
            ack_reg   <= 1'b0;
         end else begin
            ack_reg <= own;
            if (own) begin
               rdata_reg <= ram_rdata;
            end
         end
      end

      assign rdata_arr[gi] = rdata_reg;
      assign ack_arr[gi]   = ack_reg;
   end

   assign ack_a     = ack_arr[0];
   assign ack_b     = ack_arr[1];
   assign rdata_a   = rdata_arr[0];
   assign rdata_b   = rdata_arr[1];
   assign ram_cs    = ram_cs_reg;
   assign ram_we    = ram_we_reg;
   assign ram_addr  = ram_addr_reg;
   assign ram_wdata = ram_wdata_reg;
   assign busy      = busy_reg;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, RAM address width (32 words).
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 clock  input  1  sole clock; all state updates on posedge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 req_a  input  1  port A access request, level, held until ack_a.
REQ-006 we_a  input  1  port A write (1) / read (0).
REQ-007 addr_a  input  ADDR_W  port A word address.
REQ-008 wdata_a  input  DATA_W  port A write data.
REQ-009 ack_a  output  1  port A completion pulse, one cycle.
REQ-010 rdata_a  output  DATA_W  port A read data, valid while ack_a=1, held after.
REQ-011 req_b, we_b, addr_b, wdata_b, ack_b, rdata_b  same directions, widths and meanings for port B.
REQ-012 ram_cs  output  1  RAM chip select.
REQ-013 ram_we  output  1  RAM write enable (RAM writes on negedge while ram_cs=1 and ram_we=1).
REQ-014 ram_addr  output  ADDR_W  RAM address.
REQ-015 ram_wdata  output  DATA_W  RAM write data.
REQ-016 ram_rdata  input  DATA_W  RAM asynchronous read data for ram_addr.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; all outputs registered.
REQ-019 IDLE, no request: stay IDLE, ram_cs=0, ram_we=0.
REQ-020 IDLE, exactly one req high: grant that port, latch its we/addr/wdata into ram_we/ram_addr/ram_wdata, set ram_cs=1, go ACCESS.
REQ-021 IDLE, both req high: grant port not granted last (round-robin); loser waits, its req stays high.
REQ-022 ACCESS (exactly one cycle): ram_cs=1; ram_we/ram_addr/ram_wdata stable for the whole cycle; requester inputs ignored.
REQ-023 End of ACCESS: sample ram_rdata into owner's rdata register (write yields written data, read-during-write value); other port's rdata unchanged; ram_cs=0, ram_we=0; owner's ack set; go RESP.
REQ-024 RESP (exactly one cycle): owner's ack=1, other ack=0; last-grant pointer updated to owner; go IDLE.
REQ-025 ram_addr and ram_wdata hold last value outside ACCESS.
REQ-026 Latency: req sampled high at posedge N (IDLE) -> ram_cs high cycle N+1 -> ack high cycle N+2; throughput one transaction per 3 cycles.
REQ-027 Requester deasserts req on the posedge at which ack is sampled high; req still high in the following IDLE cycle counts as a new request.
REQ-028 ack_a and ack_b never high simultaneously; ram_cs never high outside ACCESS.
REQ-029 Request changes (addr/we/wdata) after grant do not affect the in-flight access.
REQ-030 Address wraps only via ADDR_W width; no range checks.

Reset
REQ-031 reset_n=0 at posedge: state=IDLE, ack_a=ack_b=0, rdata_a=rdata_b=0, ram_cs=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0, last-grant=B (A wins first tie).
REQ-032 Reset during ACCESS or RESP aborts the transaction: no ack issued, outputs as REQ-031 next cycle; a RAM write already performed at the preceding negedge is not undone.
REQ-033 reset_n overrides all requests in the same cycle.

Verification
REQ-034 A write addr 5 data 0xDEADBEEF, then A read addr 5 -> ram_we=1 one cycle with ram_addr=5; second ack_a with rdata_a=0xDEADBEEF, each ack two cycles after req.
REQ-035 req_a and req_b high same cycle after reset, both reads -> A granted first (ack_a cycle N+2), B next (ack_b cycle N+5); never both acks.
REQ-036 Both held continuously for 4 transactions -> grant order A,B,A,B; ram_cs duty 1 of every 3 cycles.
REQ-037 B write addr 31 0x12345678, addr_b changed to 0 during ACCESS -> RAM word 31 = 0x12345678, word 0 unchanged, rdata_b=0x12345678.
REQ-038 reset_n=0 during ACCESS of A read -> no ack_a, rdata_a=0, ram_cs=0, busy=0 next cycle; after release, A request completes normally.
REQ-039 Idle with no requests for 10 cycles -> ram_cs=0, busy=0, acks=0 throughout.
